// File: rtl/gpio_bank.sv
`default_nettype none
// ============================================================================
// Module   : gpio_bank
// Purpose  : WIDTH-pin GPIO with direction/output registers, atomic set/clear,
//            synchronised inputs and edge-detect interrupts with W1C status.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_bank #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             we,
    input  logic             re,
    input  logic [2:0]       addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             irq,
    inout  wire  [WIDTH-1:0] ioPin
);

    localparam logic [2:0] c_ADDR_DOUT    = 3'd0;
    localparam logic [2:0] c_ADDR_DIR     = 3'd1;
    localparam logic [2:0] c_ADDR_DIN     = 3'd2;
    localparam logic [2:0] c_ADDR_RISE_EN = 3'd3;
    localparam logic [2:0] c_ADDR_FALL_EN = 3'd4;
    localparam logic [2:0] c_ADDR_STATUS  = 3'd5;
    localparam logic [2:0] c_ADDR_SET     = 3'd6;
    localparam logic [2:0] c_ADDR_CLR     = 3'd7;

    logic [WIDTH-1:0] r_dout;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_rise_en;
    logic [WIDTH-1:0] r_fall_en;
    logic [WIDTH-1:0] r_status;
    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_rdata;
    logic             r_rvalid;

    logic [WIDTH-1:0] w_din;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_rsel;

    assign w_din = r_sync[SYNC_STAGES-1];
    assign w_set = (w_din & ~r_prev & r_rise_en) | (~w_din & r_prev & r_fall_en);
    assign w_clr = (we && addr == c_ADDR_STATUS) ? wdata : '0;

    // Read mux sees pre-write register values, so a same-cycle write is not visible.
    always_comb begin
        w_rsel = '0;
        case (addr)
            c_ADDR_DOUT:    w_rsel = r_dout;
            c_ADDR_DIR:     w_rsel = r_dir;
            c_ADDR_DIN:     w_rsel = w_din;
            c_ADDR_RISE_EN: w_rsel = r_rise_en;
            c_ADDR_FALL_EN: w_rsel = r_fall_en;
            c_ADDR_STATUS:  w_rsel = r_status;
            default:        w_rsel = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            r_dout    <= '0;
            r_dir     <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_status  <= '0;
            r_prev    <= '0;
            r_rdata   <= '0;
            r_rvalid  <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= ioPin;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_prev <= w_din;
            // A new edge outranks a clear of the same bit.
            r_status <= (r_status & ~w_clr) | w_set;

            if (we) begin
                case (addr)
                    c_ADDR_DOUT:    r_dout    <= wdata;
                    c_ADDR_DIR:     r_dir     <= wdata;
                    c_ADDR_RISE_EN: r_rise_en <= wdata;
                    c_ADDR_FALL_EN: r_fall_en <= wdata;
                    c_ADDR_SET:     r_dout    <= r_dout | wdata;
                    c_ADDR_CLR:     r_dout    <= r_dout & ~wdata;
                    default:        ;
                endcase
            end

            r_rvalid <= re;
            if (re) r_rdata <= w_rsel;
        end
    end

    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;
    assign irq    = |r_status;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pad
        assign ioPin[i] = r_dir[i] ? r_dout[i] : 1'bz;
    end

endmodule
`default_nettype wire

// File: tb/tb_gpio_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_bank
// Purpose  : Directed self-checking bench for gpio_bank with a read scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_bank;

    localparam int WIDTH = 8;

    logic             clk;
    logic             RST;
    logic             we;
    logic             re;
    logic [2:0]       addr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic             rvalid;
    logic             irq;
    wire  [WIDTH-1:0] ioPin;

    logic [WIDTH-1:0] r_pad_val;
    logic [WIDTH-1:0] r_pad_en;

    int total;
    int bad;
    logic [WIDTH-1:0] exp_q[$];

    gpio_bank #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
        .clk    (clk),
        .RST    (RST),
        .we     (we),
        .re     (re),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .rvalid (rvalid),
        .irq    (irq),
        .ioPin  (ioPin)
    );

    for (genvar i = 0; i < WIDTH; i++) begin : g_tb_pad
        assign ioPin[i] = r_pad_en[i] ? r_pad_val[i] : 1'bz;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [WIDTH-1:0] d);
        @(negedge clk);
        we = 1'b1; addr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    // Expected value goes into the scoreboard when the read is issued.
    task automatic rd(input string tag, input logic [2:0] a, input logic [WIDTH-1:0] exp);
        @(negedge clk);
        re = 1'b1; addr = a;
        exp_q.push_back(exp);
        tick();
        re = 1'b0;
        check({tag, "_rvalid"}, {31'd0, rvalid}, 32'd1);
        if (exp_q.size() > 0) check(tag, {24'd0, rdata}, {24'd0, exp_q.pop_front()});
    endtask

    initial begin
        total = 0; bad = 0;
        RST = 1'b1; we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
        r_pad_en = 8'hFF; r_pad_val = 8'h5A;

        // Reset state and readback of every address
        repeat (3) tick();
        RST = 1'b0;
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        repeat (3) tick();
        rd("rst_rd0", 3'd0, 8'h00);
        rd("rst_rd1", 3'd1, 8'h00);
        rd("rst_rd2", 3'd2, 8'h5A);
        rd("rst_rd3", 3'd3, 8'h00);
        rd("rst_rd4", 3'd4, 8'h00);
        rd("rst_rd5", 3'd5, 8'h00);
        rd("rst_rd6", 3'd6, 8'h00);
        rd("rst_rd7", 3'd7, 8'h00);
        tick();
        check("rvalid_one_cycle", {31'd0, rvalid}, 32'd0);

        // Output drive, set/clear and readback through the synchroniser
        r_pad_en = 8'h00;
        wr(3'd1, 8'hFF);
        wr(3'd0, 8'hA5);
        check("pad_a5", {24'd0, ioPin}, 32'hA5);
        wr(3'd6, 8'h0A);
        check("pad_set", {24'd0, ioPin}, 32'hAF);
        wr(3'd7, 8'h81);
        check("pad_clr", {24'd0, ioPin}, 32'h2E);
        tick(); tick();
        rd("din_driven", 3'd2, 8'h2E);
        rd("dout_rd", 3'd0, 8'h2E);
        check("no_irq_disabled", {31'd0, irq}, 32'd0);

        // Rising edge on pin0: status appears two edges after first sample
        wr(3'd1, 8'h00);
        r_pad_en = 8'hFF; r_pad_val = 8'h00;
        repeat (4) tick();
        wr(3'd3, 8'h01);
        @(negedge clk); r_pad_val = 8'h01;
        tick();
        check("rise_e0", {31'd0, irq}, 32'd0);
        tick();
        check("rise_e1", {31'd0, irq}, 32'd0);
        tick();
        check("rise_e2", {31'd0, irq}, 32'd1);
        rd("rise_status", 3'd5, 8'h01);
        @(negedge clk); r_pad_val = 8'h00;
        repeat (4) tick();
        rd("fall_ignored", 3'd5, 8'h01);
        wr(3'd5, 8'h01);
        check("w1c_irq", {31'd0, irq}, 32'd0);

        // Both-edge detection on pin4 with a clear between the edges
        wr(3'd3, 8'h10);
        wr(3'd4, 8'h10);
        @(negedge clk); r_pad_val = 8'h10;
        tick(); tick(); tick();
        check("pin4_rise_irq", {31'd0, irq}, 32'd1);
        rd("pin4_rise_st", 3'd5, 8'h10);
        wr(3'd5, 8'h10);
        check("pin4_clr_irq", {31'd0, irq}, 32'd0);
        @(negedge clk); r_pad_val = 8'h00;
        tick(); tick();
        check("pin4_fall_e1", {31'd0, irq}, 32'd0);
        tick();
        check("pin4_fall_irq", {31'd0, irq}, 32'd1);
        rd("pin4_fall_st", 3'd5, 8'h10);
        wr(3'd5, 8'h10);

        // Set and W1C on the same edge: set wins
        wr(3'd3, 8'h01);
        @(negedge clk); r_pad_val = 8'h01;
        tick(); tick();
        wr(3'd5, 8'h01);
        check("collide_irq", {31'd0, irq}, 32'd1);
        rd("collide_st", 3'd5, 8'h01);
        wr(3'd5, 8'h01);
        check("collide_clr", {31'd0, irq}, 32'd0);

        // Simultaneous write and read returns the pre-write value
        wr(3'd0, 8'h00);
        @(negedge clk);
        we = 1'b1; re = 1'b1; addr = 3'd0; wdata = 8'h33;
        exp_q.push_back(8'h00);
        tick();
        we = 1'b0; re = 1'b0;
        check("wr_rd_rvalid", {31'd0, rvalid}, 32'd1);
        if (exp_q.size() > 0) check("wr_rd_old", {24'd0, rdata}, {24'd0, exp_q.pop_front()});
        rd("wr_rd_new", 3'd0, 8'h33);

        // Reset during a read discards it and clears everything
        wr(3'd5, 8'hFF);
        @(negedge clk);
        re = 1'b1; addr = 3'd0; RST = 1'b1;
        tick();
        re = 1'b0;
        check("rst_rd_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_rd_rdata", {24'd0, rdata}, 32'd0);
        @(negedge clk); RST = 1'b0;
        repeat (3) tick();
        rd("rst2_dout", 3'd0, 8'h00);
        rd("rst2_risen", 3'd3, 8'h00);
        rd("rst2_din", 3'd2, 8'h01);
        check("rst2_irq", {31'd0, irq}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gpio_bank.md
Name: gpio_bank

Overview:
Parametrised successor to the 8-bit GPIO port. Provides WIDTH bidirectional pins with per-pin direction and output registers, atomic set/clear of output bits, and synchronised input sampling. Adds rising/falling edge detection with sticky write-1-to-clear interrupt status and a single irq line. Sits on the processor's simple register bus as a peripheral; ioPin connects to the top-level pads.

Parameters:
WIDTH, 8, number of pins; also the width of the data bus (1..32)
SYNC_STAGES, 2, input synchroniser depth in flops (>=2)

Ports:
clk  input  1  system clock, all logic on rising edge
RST  input  1  synchronous reset, active-high
we  input  1  register write strobe, one cycle per write
re  input  1  register read strobe, one cycle per read
addr  input  3  register address
wdata  input  WIDTH  write data
rdata  output  WIDTH  registered read data
rvalid  output  1  high for one cycle when rdata is valid
irq  output  1  interrupt, high while any status bit is set
ioPin  inout  WIDTH  pad pins; bit i is driven when DIR[i]=1, else high-Z

Behaviour:
- Reset: sampled on a clk edge while RST=1. Clears DATA_OUT, DIR, RISE_EN, FALL_EN, STATUS, the sync chain, the previous-sample register, rdata and rvalid to 0. After reset: all pins high-Z, irq=0. RST overrides any same-cycle we/re. Reset mid-transaction discards a pending read (rvalid=0).
- Register map (addr):
  - 0 DATA_OUT, RW.
  - 1 DIR, RW; 1=output.
  - 2 DATA_IN, RO; synchronised pin value. Writes are ignored.
  - 3 RISE_EN, RW.
  - 4 FALL_EN, RW.
  - 5 STATUS, R/W1C.
  - 6 SET, WO; DATA_OUT |= wdata. Reads return 0.
  - 7 CLR, WO; DATA_OUT &= ~wdata. Reads return 0.
- Pad drive: ioPin[i] = DIR[i] ? DATA_OUT[i] : 1'bz. This is combinational from the registers, so a change takes effect the cycle after the write edge.
- Writes: take effect at the clk edge where we=1.
- Reads: re=1 at edge R loads rdata and sets rvalid=1 at R, valid for one cycle. Otherwise rvalid=0 and rdata holds its last value. If we and re are both high in the same cycle, both are performed and rdata returns the pre-write value.
- Input path:
  - ioPin is sampled into an SYNC_STAGES-deep chain; the last stage is DATA_IN.
  - Output-driven pins are sampled too, so readback and edges on driven pins work.
  - A pin change first sampled at edge E appears in DATA_IN after edge E+SYNC_STAGES-1.
- Edge detect:
  - prev <= DATA_IN each cycle.
  - rise = DATA_IN & ~prev; fall = ~DATA_IN & prev.
  - Per bit: STATUS[i] is set at edge E+SYNC_STAGES when (rise[i]&RISE_EN[i]) | (fall[i]&FALL_EN[i]).
  - Enabling both RISE_EN and FALL_EN on a bit gives both-edge detection.
- STATUS clear: a write to addr 5 clears the bits where wdata=1. If a set and a clear hit the same bit in the same cycle, the set wins.
- Interrupt enables do not retroactively set STATUS: edges that occurred while disabled are lost.
- irq = |STATUS, combinational from the registers. It is not masked further; software masks via the enables.
- Pulses shorter than one clk period may be missed; this is documented behaviour, not an error.
- Addresses are fully decoded; no undefined addresses exist at 3 bits.

Test Plan:
- Reset then read all addrs -> rvalid pulses one cycle after each re. Every read returns 0 except DATA_IN, which equals the pad value; ioPin is all Z.
- Write DIR=0xFF, DATA_OUT=0xA5 -> ioPin=0xA5 the next cycle. Write SET 0x0A -> 0xAF. Write CLR 0x81 -> 0x2E. DATA_IN reads 0x2E after SYNC_STAGES cycles.
- DIR=0, RISE_EN=0x01; drive pin0 0->1 before edge E -> STATUS=0x01 and irq=1 after edge E+2, not earlier. A falling edge with FALL_EN=0 causes no change.
- RISE_EN=FALL_EN=0x10; pulse pin4 high for 5 cycles -> STATUS[4] set on the rise. Write 0x10 to STATUS -> irq=0. The fall then sets it again.
- Drive a rising edge that lands on the same edge as a W1C write to bit0 -> STATUS[0] remains 1.
- Same-cycle we+re on addr 0 (0x00 -> write 0x33) -> rdata=0x00, and a subsequent read gives 0x33. Assert RST during an active read -> rvalid=0 and all registers 0.
